// File: rtl/map_tile_writer_if.sv
// Bundle of request, response and map-RAM signals for the tile map writer.
// The slave modport is the writer itself; master is the surrounding game/RAM side.
interface map_tile_writer_if #(
    parameter int MAP_COLS = 40
);
    logic                    req_valid;
    logic                    req_ready;
    logic [5:0]              req_x;
    logic [4:0]              req_y;
    logic                    req_op;
    logic [3:0]              req_tile;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [3:0]              resp_old_tile;
    logic                    resp_hit;
    logic                    resp_err;
    logic [10:0]             pellets_eaten;

    logic                    vga_blank;
    logic                    map_rd_own;
    logic [5:0]              map_rdaddress;
    logic [4*MAP_COLS-1:0]   map_q;
    logic                    map_wren;
    logic [5:0]              map_wraddress;
    logic [4*MAP_COLS-1:0]   map_data;

    modport slave (
        input  req_valid, req_x, req_y, req_op, req_tile,
        input  resp_ready, vga_blank, map_q,
        output req_ready, resp_valid, resp_old_tile, resp_hit, resp_err, pellets_eaten,
        output map_rd_own, map_rdaddress, map_wren, map_wraddress, map_data
    );

    modport master (
        output req_valid, req_x, req_y, req_op, req_tile,
        output resp_ready, vga_blank, map_q,
        input  req_ready, resp_valid, resp_old_tile, resp_hit, resp_err, pellets_eaten,
        input  map_rd_own, map_rdaddress, map_wren, map_wraddress, map_data
    );
endinterface

// File: rtl/map_tile_writer.sv
// Tile map write-side controller: one read-modify-write of a 160-bit row word per
// request, borrowing the shared RAM read port only while the VGA path is blanked.
//
// state        | meaning
// S_IDLE       | ready for a request; out-of-range coordinates go straight to S_RESP
// S_WAIT_BLANK | request latched, waiting for vga_blank to borrow the read port
// S_READ       | read port owned, row address held for RD_LAT cycles
// S_CAPTURE    | row word valid on map_q; decide new nibble / hit / write
// S_WRITE      | single-cycle write strobe with the merged row word
// S_RESP       | response held until resp_ready
module map_tile_writer #(
    parameter int MAP_COLS    = 40,
    parameter int MAP_ROWS    = 30,
    parameter int RD_LAT      = 1,
    parameter int EMPTY_TILE  = 0,
    parameter int PELLET_TILE = 2,
    parameter int POWER_TILE  = 3
) (
    input  logic               clk,
    input  logic               reset,
    map_tile_writer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BLANK,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_t;

    localparam int         ROW_W    = 4 * MAP_COLS;
    localparam logic [5:0] COLS_L   = 6'(MAP_COLS);
    localparam logic [4:0] ROWS_L   = 5'(MAP_ROWS);
    localparam logic [3:0] EMPTY_L  = 4'(EMPTY_TILE);
    localparam logic [3:0] PELLET_L = 4'(PELLET_TILE);
    localparam logic [3:0] POWER_L  = 4'(POWER_TILE);
    localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);
    localparam logic [10:0] CNT_MAX = 11'd2047;

    state_t             r_state;
    logic [5:0]         r_x;
    logic [4:0]         r_y;
    logic               r_op;
    logic [3:0]         r_tile;
    logic [3:0]         r_lat;
    logic               r_rd_own;
    logic [5:0]         r_rdaddress;
    logic               r_wren;
    logic [5:0]         r_wraddress;
    logic [ROW_W-1:0]   r_data;
    logic               r_resp_valid;
    logic [3:0]         r_old;
    logic               r_hit;
    logic               r_err;
    logic [10:0]        r_pellets;

    logic               w_req_err;
    logic [7:0]         w_idx;
    logic [3:0]         w_old;
    logic               w_is_pellet;
    logic [3:0]         w_new;
    logic [ROW_W-1:0]   w_merged;

    assign w_req_err   = (bus.req_x >= COLS_L) || (bus.req_y >= ROWS_L);
    assign w_idx       = {r_x, 2'b00};
    assign w_old       = bus.map_q[w_idx +: 4];
    assign w_is_pellet = (w_old == PELLET_L) || (w_old == POWER_L);
    assign w_new       = r_op ? EMPTY_L : r_tile;

    // Row word with only the addressed nibble replaced
    always_comb begin
        w_merged              = bus.map_q;
        w_merged[w_idx +: 4]  = w_new;
    end

    // Sequencer with registered outputs; sync reset aborts any request in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_op         <= 1'b0;
            r_tile       <= '0;
            r_lat        <= '0;
            r_rd_own     <= 1'b0;
            r_rdaddress  <= '0;
            r_wren       <= 1'b0;
            r_wraddress  <= '0;
            r_data       <= '0;
            r_resp_valid <= 1'b0;
            r_old        <= '0;
            r_hit        <= 1'b0;
            r_err        <= 1'b0;
            r_pellets    <= '0;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_x    <= bus.req_x;
                        r_y    <= bus.req_y;
                        r_op   <= bus.req_op;
                        r_tile <= bus.req_tile;
                        if (w_req_err) begin
                            r_err        <= 1'b1;
                            r_hit        <= 1'b0;
                            r_old        <= '0;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_state <= S_WAIT_BLANK;
                        end
                    end
                end
                S_WAIT_BLANK: begin
                    if (bus.vga_blank) begin
                        r_rd_own    <= 1'b1;
                        r_rdaddress <= {1'b0, r_y};
                        r_lat       <= LAT_INIT;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    // Losing blank mid-read means the VGA path needs the port back: retry later
                    if (!bus.vga_blank) begin
                        r_rd_own    <= 1'b0;
                        r_rdaddress <= '0;
                        r_state     <= S_WAIT_BLANK;
                    end else if (r_lat == 4'd0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    r_rd_own    <= 1'b0;
                    r_rdaddress <= '0;
                    r_old       <= w_old;
                    r_err       <= 1'b0;
                    r_data      <= w_merged;
                    if (!r_op || w_is_pellet) begin
                        r_wren      <= 1'b1;
                        r_wraddress <= {1'b0, r_y};
                        r_hit       <= r_op;
                        if (r_op && (r_pellets != CNT_MAX)) begin
                            r_pellets <= r_pellets + 11'd1;
                        end
                        r_state <= S_WRITE;
                    end else begin
                        r_hit        <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_WRITE: begin
                    r_wraddress  <= '0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_old        <= '0;
                        r_hit        <= 1'b0;
                        r_err        <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = (r_state == S_IDLE);
    assign bus.map_rd_own    = r_rd_own;
    assign bus.map_rdaddress = r_rdaddress;
    assign bus.map_wren      = r_wren;
    assign bus.map_wraddress = r_wraddress;
    assign bus.map_data      = r_data;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_old_tile = r_old;
    assign bus.resp_hit      = r_hit;
    assign bus.resp_err      = r_err;
    assign bus.pellets_eaten = r_pellets;

endmodule
